// File: rtl/dmem_pkg.sv
// Shared types and lane helpers for the handshaked data memory.
// Used by data_mem_responder and dmem_lane_align.
package dmem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_e;

    // The reserved encoding behaves as a word access.
    function automatic logic [1:0] norm_size(input logic [1:0] size);
        return (size == 2'b11) ? SZ_WORD : size;
    endfunction

    function automatic logic [1:0] norm_lane(
        input logic [1:0] size,
        input logic [1:0] lane
    );
        logic [1:0] l;
        l = lane;
        if (size == SZ_HALF) l = {lane[1], 1'b0};
        if (size == SZ_WORD) l = 2'b00;
        return l;
    endfunction

    function automatic logic [3:0] lane_strb(
        input logic [1:0] size,
        input logic [1:0] lane
    );
        logic [3:0] s;
        unique case (size)
            SZ_BYTE: s = 4'b0001 << lane;
            SZ_HALF: s = lane[1] ? 4'b1100 : 4'b0011;
            default: s = 4'b1111;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational lane steering: store replication/strobes and
// load extraction with zero/sign extension.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [1:0]  size_i,
    input  logic [1:0]  lane_i,
    input  logic        unsigned_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rword_i,
    output logic [31:0] wdata_o,
    output logic [3:0]  strb_o,
    output logic [31:0] rdata_o
);

    logic [31:0] shifted;

    assign strb_o  = lane_strb(size_i, lane_i);
    assign shifted = rword_i >> {lane_i, 3'b000};

    always_comb begin
        wdata_o = wdata_i;
        rdata_o = shifted;
        unique case (size_i)
            SZ_BYTE: begin
                wdata_o = {4{wdata_i[7:0]}};
                rdata_o = unsigned_i ? {24'h0, shifted[7:0]}
                        : {{24{shifted[7]}}, shifted[7:0]};
            end
            SZ_HALF: begin
                wdata_o = {2{wdata_i[15:0]}};
                rdata_o = unsigned_i ? {16'h0, shifted[15:0]}
                        : {{16{shifted[15]}}, shifted[15:0]};
            end
            default: begin
                wdata_o = wdata_i;
                rdata_o = shifted;
            end
        endcase
    end

endmodule

// File: rtl/data_mem_responder.sv
// Request/response data memory with byte/half/word lanes.
// DMEM_ERR_EN enables misalignment, size and range errors.
module data_mem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 64,
    parameter int ADDR_W      = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err
);

    localparam int IDX_W  = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int WIDX_W = ADDR_W - 2;

    state_e            state_q, state_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [1:0]        size_q, size_d;
    logic              uns_q, uns_d;
    logic [31:0]       rdata_q, rdata_d;

    logic [31:0]       mem_q [DEPTH_WORDS];

    logic [WIDX_W-1:0] widx_full;
    logic [IDX_W-1:0]  widx;
    logic [1:0]        size_n;
    logic [1:0]        lane_n;
    logic              err_c;
    logic [31:0]       rword;
    logic [31:0]       wdata_al;
    logic [3:0]        strb;
    logic [31:0]       rdata_al;

    assign widx_full = addr_q[ADDR_W-1:2];
    assign widx      = IDX_W'(widx_full % WIDX_W'(DEPTH_WORDS));
    assign size_n    = norm_size(size_q);
    assign lane_n    = norm_lane(size_n, addr_q[1:0]);
    assign rword     = mem_q[widx];

`ifdef DMEM_ERR_EN
    logic err_q, err_d;

    assign err_c = (size_q == 2'b11)
                || (size_q == SZ_HALF && addr_q[0])
                || (size_q == SZ_WORD && addr_q[1:0] != 2'b00)
                || (widx_full >= WIDX_W'(DEPTH_WORDS));
    assign rsp_err = err_q;
`else
    assign err_c   = 1'b0;
    assign rsp_err = 1'b0;
`endif

    dmem_lane_align u_align (
        .size_i     (size_n),
        .lane_i     (lane_n),
        .unsigned_i (uns_q),
        .wdata_i    (wdata_q),
        .rword_i    (rword),
        .wdata_o    (wdata_al),
        .strb_o     (strb),
        .rdata_o    (rdata_al)
    );

    assign req_ready = (state_q == IDLE);
    assign rsp_valid = (state_q == RESP);
    assign rsp_rdata = rdata_q;

    // Async reset drops state to IDLE, so an aborted access never writes.
    always_ff @(posedge clk) begin
        if (state_q == ACCESS && we_q && !err_c) begin
            for (int b = 0; b < 4; b++) begin
                if (strb[b]) mem_q[widx][8*b +: 8] <= wdata_al[8*b +: 8];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        size_d  = size_q;
        uns_d   = uns_q;
        rdata_d = rdata_q;
`ifdef DMEM_ERR_EN
        err_d   = err_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    we_d    = req_we;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    size_d  = req_size;
                    uns_d   = req_unsigned;
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                rdata_d = (we_q || err_c) ? 32'h0 : rdata_al;
`ifdef DMEM_ERR_EN
                err_d   = err_c;
`endif
                state_d = RESP;
            end
            RESP: begin
                if (rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= 32'h0;
            size_q  <= SZ_BYTE;
            uns_q   <= 1'b0;
            rdata_q <= 32'h0;
`ifdef DMEM_ERR_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            rdata_q <= rdata_d;
`ifdef DMEM_ERR_EN
            err_q   <= err_d;
`endif
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder against a byte-array model.
// Honors DMEM_ERR_EN when it is defined for the build.
module tb_data_mem_responder;

    localparam int DEPTH = 64;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] mb [DEPTH*4];

    data_mem_responder #(.DEPTH_WORDS(DEPTH), .ADDR_W(32)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model(input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [1:0] size,
                         input logic uns, output logic [31:0] rd,
                         output logic err);
        int widx, lane, nb, base, sz;
        logic [31:0] v;
        widx = int'(addr >> 2);
        lane = int'(addr[1:0]);
        sz   = (size == 2'b11) ? 2 : int'(size);
`ifdef DMEM_ERR_EN
        err = (size == 2'b11) || (size == 2'b01 && addr[0])
           || (size == 2'b10 && addr[1:0] != 0) || (widx >= DEPTH);
`else
        err = 1'b0;
        if (sz == 1) lane = lane & 2;
        if (sz == 2) lane = 0;
        widx = widx % DEPTH;
`endif
        nb   = 1 << sz;
        base = widx * 4 + lane;
        rd   = 32'h0;
        if (!err && we) begin
            for (int i = 0; i < nb; i++) mb[base+i] = wdata[8*i +: 8];
        end else if (!err) begin
            v = 32'h0;
            for (int i = 0; i < nb; i++) v[8*i +: 8] = mb[base+i];
            if (!uns && v[8*nb-1])
                for (int i = nb; i < 4; i++) v[8*i +: 8] = 8'hFF;
            rd = v;
        end
    endtask

    task automatic xfer(input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [1:0] size,
                        input logic uns, input int stall,
                        output logic [31:0] rd, output logic e);
        logic [31:0] erd;
        logic        eerr;
        model(we, addr, wdata, size, uns, erd, eerr);
        @(negedge clk);
        chk("idle_ready", req_ready, 1);
        req_we       = we;
        req_addr     = addr;
        req_wdata    = wdata;
        req_size     = size;
        req_unsigned = uns;
        req_valid    = 1'b1;
        rsp_ready    = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("access_ready", req_ready, 0);
        chk("access_valid", rsp_valid, 0);
        rsp_ready = (stall == 0);
        @(posedge clk); #1;
        chk("rsp_valid", rsp_valid, 1);
        rd = rsp_rdata;
        e  = rsp_err;
        chk("rdata", rd, erd);
        chk("err", e, eerr);
        for (int i = 0; i < stall; i++) begin
            if (i < stall - 1) begin
                req_valid = 1'b1;
                req_we    = 1'b1;
                req_size  = 2'b10;
                req_wdata = $urandom;
            end else begin
                req_valid = 1'b0;
            end
            @(posedge clk); #1;
            chk("stall_valid", rsp_valid, 1);
            chk("stall_rdata", rsp_rdata, erd);
            chk("stall_err", rsp_err, eerr);
            chk("stall_ready", req_ready, 0);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        chk("hs_valid", rsp_valid, 0);
        chk("hs_ready", req_ready, 1);
    endtask

    logic [31:0] rd;
    logic        e;
    logic [31:0] a;
    logic [1:0]  s;

    initial begin
        rst_n = 1'b0;
        req_valid = 1'b0;
        req_we = 1'b0;
        req_addr = 32'h0;
        req_wdata = 32'h0;
        req_size = 2'b00;
        req_unsigned = 1'b0;
        rsp_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", req_ready, 1);
        chk("rst_valid", rsp_valid, 0);
        chk("rst_rdata", rsp_rdata, 0);
        chk("rst_err", rsp_err, 0);
        rst_n = 1'b1;

        for (int w = 0; w < DEPTH; w++)
            xfer(1'b1, 32'(w * 4), $urandom, 2'b10, 1'b0, 0, rd, e);

        xfer(1'b1, 32'd4, 32'h0A0B0C0D, 2'b10, 1'b0, 0, rd, e);
        xfer(1'b1, 32'd8, 32'h11223344, 2'b10, 1'b0, 0, rd, e);
        chk("st_rdata_zero", rd, 0);
        xfer(1'b0, 32'd8, 32'h0, 2'b10, 1'b0, 0, rd, e);
        chk("word_ld", rd, 32'h11223344);
        chk("word_ld_err", e, 0);
        xfer(1'b1, 32'd9, 32'h00000080, 2'b00, 1'b0, 0, rd, e);
        xfer(1'b0, 32'd9, 32'h0, 2'b00, 1'b0, 0, rd, e);
        chk("byte_ld_s", rd, 32'hFFFFFF80);
        xfer(1'b0, 32'd9, 32'h0, 2'b00, 1'b1, 0, rd, e);
        chk("byte_ld_u", rd, 32'h00000080);
        xfer(1'b0, 32'd8, 32'h0, 2'b10, 1'b0, 5, rd, e);
        chk("word_ld_bp", rd, 32'h11228044);
        xfer(1'b1, 32'd10, 32'h0000BEEF, 2'b01, 1'b0, 0, rd, e);
        xfer(1'b0, 32'd10, 32'h0, 2'b01, 1'b0, 0, rd, e);
        chk("half_ld_s", rd, 32'hFFFFBEEF);

        xfer(1'b0, 32'd6, 32'h0, 2'b10, 1'b0, 0, rd, e);
`ifdef DMEM_ERR_EN
        chk("mis_err", e, 1);
        chk("mis_rdata", rd, 0);
`endif
        xfer(1'b1, 32'd256, 32'hCAFEF00D, 2'b10, 1'b0, 0, rd, e);
`ifdef DMEM_ERR_EN
        chk("oor_err", e, 1);
`endif
        xfer(1'b0, 32'd0, 32'h0, 2'b10, 1'b0, 0, rd, e);

        // Reset during ACCESS must abort the store.
        @(negedge clk);
        req_we = 1'b1;
        req_addr = 32'd4;
        req_wdata = 32'hDEADBEEF;
        req_size = 2'b10;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("mid_acc_ready", req_ready, 0);
        rst_n = 1'b0;
        #1;
        chk("mid_acc_rst_ready", req_ready, 1);
        chk("mid_acc_rst_valid", rsp_valid, 0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        xfer(1'b0, 32'd4, 32'h0, 2'b10, 1'b0, 0, rd, e);
        chk("abort_ld", rd, 32'h0A0B0C0D);

        // Reset during RESP drops the response at once.
        @(negedge clk);
        req_we = 1'b0;
        req_addr = 32'd8;
        req_size = 2'b10;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        chk("mid_rsp_valid", rsp_valid, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rsp_rst_valid", rsp_valid, 0);
        chk("mid_rsp_rst_rdata", rsp_rdata, 0);
        chk("mid_rsp_rst_err", rsp_err, 0);
        chk("mid_rsp_rst_ready", req_ready, 1);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        for (int n = 0; n < 200; n++) begin
            if ($urandom_range(0, 7) == 0) a = $urandom;
            else a = 32'($urandom_range(0, DEPTH * 4 + 31));
            s = 2'($urandom_range(0, 3));
            xfer(1'($urandom_range(0, 1)), a, $urandom, s,
                 1'($urandom_range(0, 1)), $urandom_range(0, 2), rd, e);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
